// File: rtl/pt2272_pkg.sv
// pt2272_pkg: shared PT2272/PT2262 symbol codes, frame states and frame length
package pt2272_pkg;
  typedef enum logic [1:0] {
    SYM_0    = 2'b00,
    SYM_1    = 2'b11,
    SYM_F    = 2'b10,
    SYM_SYNC = 2'b01
  } pt2272_sym_t;
  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    TAIL    = 2'd2
  } frame_state_t;
  localparam int FRAME_TRITS = 12;
endpackage

// File: rtl/pt2272_frame_ctrl_if.sv
// pt2272_frame_ctrl_if: symbol strobe/sym/addr_i in, D/dv/vt/frame_err out; master drives symbols, slave is the controller
interface pt2272_frame_ctrl_if #(
  parameter int ADDR_TRITS = 8,
  parameter int DATA_BITS  = 4
);
  logic                    sym_valid;
  logic [1:0]              sym;
  logic [2*ADDR_TRITS-1:0] addr_i;
  logic [DATA_BITS-1:0]    D;
  logic                    dv;
  logic                    vt;
  logic                    frame_err;
  modport master (output sym_valid, sym, addr_i, input D, dv, vt, frame_err);
  modport slave (input sym_valid, sym, addr_i, output D, dv, vt, frame_err);
endinterface

// File: rtl/pt2272_idle_timer.sv
// pt2272_idle_timer: saturating idle counter; clk/reset, clear restarts it, expired is high once TIMEOUT_CYCLES idle cycles have elapsed
module pt2272_idle_timer #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIM = W'(TIMEOUT_CYCLES);
  logic [W-1:0] idle_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) idle_cnt <= '0;
    else if (clear) idle_cnt <= '0;
    else if (idle_cnt != LIM) idle_cnt <= idle_cnt + 1'b1;
  assign expired = idle_cnt == LIM;
endmodule

// File: rtl/pt2272_frame_ctrl.sv
// pt2272_frame_ctrl: assembles 12-trit frames from clk/reset + bus (sym_valid, sym, addr_i), confirms repeated frames and drives D/dv/vt/frame_err
module pt2272_frame_ctrl
  import pt2272_pkg::*;
#(
  parameter int ADDR_TRITS     = 8,
  parameter int DATA_BITS      = 4,
  parameter int CONFIRM_FRAMES = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic clk,
  input logic reset,
  pt2272_frame_ctrl_if.slave bus
);
  localparam int NT = ADDR_TRITS + DATA_BITS;
  localparam int TW = $clog2(NT + 1);
  localparam logic [TW-1:0] LAST = TW'(NT - 1);
  localparam logic [2:0] CONF = 3'(CONFIRM_FRAMES);
  localparam logic [1:0] ST_HUNT = HUNT;
  localparam logic [1:0] ST_COLLECT = COLLECT;
  localparam logic [1:0] ST_TAIL = TAIL;
  logic [1:0]           state;
  logic [TW-1:0]        trit_cnt;
  logic [2:0]           match_cnt;
  logic [2:0]           next_match;
  logic [2*NT-1:0]      frame_buf;
  logic [DATA_BITS-1:0] cand;
  logic [DATA_BITS-1:0] d_q;
  logic [DATA_BITS-1:0] data;
  logic                 dv_q;
  logic                 vt_q;
  logic                 err_q;
  logic                 expired;
  logic                 data_ok;
  logic                 frame_ok;
  logic                 restart;
  logic                 confirm;
  logic                 is_sync;
  pt2272_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle (
    .clk     (clk),
    .reset   (reset),
    .clear   (bus.sym_valid),
    .expired (expired)
  );
  // A data trit is legal only as 00 or 11, so its low bit is the data value.
  always_comb begin
    data = '0;
    data_ok = 1'b1;
    for (int i = 0; i < DATA_BITS; i++) begin
      data[i] = frame_buf[2*(ADDR_TRITS+i)];
      data_ok = data_ok & (frame_buf[2*(ADDR_TRITS+i)] == frame_buf[2*(ADDR_TRITS+i)+1]);
    end
  end
  assign is_sync    = bus.sym == SYM_SYNC;
  assign frame_ok   = data_ok && frame_buf[2*ADDR_TRITS-1:0] == bus.addr_i;
  assign restart    = match_cnt == '0 || data != cand;
  assign next_match = restart ? 3'd1 : match_cnt == CONF ? CONF : match_cnt + 3'd1;
  // Restart counts as a fresh transition so CONFIRM_FRAMES=1 accepts every new value.
  assign confirm    = next_match == CONF && (restart || match_cnt != CONF);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_HUNT;
      trit_cnt  <= '0;
      match_cnt <= '0;
      frame_buf <= '0;
      cand      <= '0;
      d_q       <= '0;
      dv_q      <= 1'b0;
      vt_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      dv_q  <= 1'b0;
      err_q <= 1'b0;
      if (bus.sym_valid) begin
        if (state == ST_HUNT) begin
          if (is_sync) begin
            state    <= ST_COLLECT;
            trit_cnt <= '0;
          end
        end else if (state == ST_COLLECT) begin
          if (is_sync) begin
            err_q     <= 1'b1;
            match_cnt <= '0;
            trit_cnt  <= '0;
          end else begin
            frame_buf[{trit_cnt, 1'b0} +: 2] <= bus.sym;
            trit_cnt <= trit_cnt + 1'b1;
            if (trit_cnt == LAST) state <= ST_TAIL;
          end
        end else if (is_sync) begin
          state    <= ST_COLLECT;
          trit_cnt <= '0;
          if (!frame_ok) begin
            err_q     <= 1'b1;
            match_cnt <= '0;
          end else begin
            cand      <= data;
            match_cnt <= next_match;
            if (confirm) begin
              d_q  <= data;
              dv_q <= 1'b1;
              vt_q <= 1'b1;
            end
          end
        end else begin
          err_q     <= 1'b1;
          match_cnt <= '0;
          state     <= ST_HUNT;
        end
      end else if (expired) begin
        state     <= ST_HUNT;
        vt_q      <= 1'b0;
        match_cnt <= '0;
        trit_cnt  <= '0;
      end
    end
  end
  assign bus.D         = d_q;
  assign bus.dv        = dv_q;
  assign bus.vt        = vt_q;
  assign bus.frame_err = err_q;
endmodule

// File: tb/tb_pt2272_frame_ctrl.sv
// tb_pt2272_frame_ctrl: table-driven frame vectors plus short/long frame, timeout and async reset sequences
module tb_pt2272_frame_ctrl;
  import pt2272_pkg::*;
  localparam int TO = 40;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int pass_cnt = 0;
  int total = 0;
  int dv_seen = 0;
  typedef struct {
    logic [15:0] loc;
    logic [15:0] adr;
    logic [7:0]  dat;
    logic        dv;
    logic        err;
    logic [3:0]  d;
    logic        vt;
  } vec_t;
  vec_t tbl[12];
  pt2272_frame_ctrl_if #(.ADDR_TRITS(8), .DATA_BITS(4)) bus ();
  pt2272_frame_ctrl #(
    .ADDR_TRITS(8), .DATA_BITS(4), .CONFIRM_FRAMES(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.dv) dv_seen++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic strobe(input logic [1:0] s);
    bus.sym = s;
    bus.sym_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.sym_valid = 1'b0;
  endtask
  task automatic frame(input logic [15:0] a, input logic [7:0] d);
    for (int i = 0; i < 8; i++) strobe(a[2*i +: 2]);
    for (int i = 0; i < 4; i++) strobe(d[2*i +: 2]);
    strobe(2'b01);
  endtask
  initial begin
    bus.sym_valid = 1'b0;
    bus.sym = 2'b00;
    bus.addr_i = 16'hAAAA;
    tbl[0]  = '{16'hAAAA, 16'hAAAA, 8'hF3, 1'b0, 1'b0, 4'h0, 1'b0};
    tbl[1]  = '{16'hAAAA, 16'hAAAA, 8'hF3, 1'b1, 1'b0, 4'hD, 1'b1};
    tbl[2]  = '{16'hAAAA, 16'hAAAA, 8'hF3, 1'b0, 1'b0, 4'hD, 1'b1};
    tbl[3]  = '{16'hAAAA, 16'hAAAA, 8'hF0, 1'b0, 1'b0, 4'hD, 1'b1};
    tbl[4]  = '{16'hAAAA, 16'hAAAA, 8'hCC, 1'b0, 1'b0, 4'hD, 1'b1};
    tbl[5]  = '{16'hAAAA, 16'hAAAA, 8'hCC, 1'b1, 1'b0, 4'hA, 1'b1};
    tbl[6]  = '{16'hAA2A, 16'hAA2A, 8'hF0, 1'b0, 1'b0, 4'hA, 1'b1};
    tbl[7]  = '{16'hAA2A, 16'hAAEA, 8'hF0, 1'b0, 1'b1, 4'hA, 1'b1};
    tbl[8]  = '{16'hAA2A, 16'hAA2A, 8'hF0, 1'b0, 1'b0, 4'hA, 1'b1};
    tbl[9]  = '{16'hAA2A, 16'hAA2A, 8'hF8, 1'b0, 1'b1, 4'hA, 1'b1};
    tbl[10] = '{16'hAA2A, 16'hAA2A, 8'hF0, 1'b0, 1'b0, 4'hA, 1'b1};
    tbl[11] = '{16'hAA2A, 16'hAA2A, 8'hF0, 1'b1, 1'b0, 4'hC, 1'b1};
    repeat (2) @(posedge clk);
    #1;
    chk("reset D", bus.D, 0);
    chk("reset dv", bus.dv, 0);
    chk("reset vt", bus.vt, 0);
    chk("reset frame_err", bus.frame_err, 0);
    reset = 1'b0;
    repeat (3) strobe(2'b11);
    strobe(2'b01);
    for (int i = 0; i < 12; i++) begin
      bus.addr_i = tbl[i].loc;
      frame(tbl[i].adr, tbl[i].dat);
      chk($sformatf("row%0d dv", i), bus.dv, tbl[i].dv);
      chk($sformatf("row%0d frame_err", i), bus.frame_err, tbl[i].err);
      chk($sformatf("row%0d D", i), bus.D, tbl[i].d);
      chk($sformatf("row%0d vt", i), bus.vt, tbl[i].vt);
    end
    bus.addr_i = 16'hAAAA;
    repeat (7) strobe(2'b10);
    strobe(2'b01);
    chk("short frame_err", bus.frame_err, 1);
    chk("short state", dut.state, 2'(COLLECT));
    repeat (12) strobe(2'b10);
    chk("tail state", dut.state, 2'(TAIL));
    strobe(2'b10);
    chk("long frame_err", bus.frame_err, 1);
    chk("long state", dut.state, 2'(HUNT));
    strobe(2'b01);
    chk("resync frame_err", bus.frame_err, 0);
    chk("resync state", dut.state, 2'(COLLECT));
    frame(16'hAAAA, 8'hF3);
    chk("post-long first dv", bus.dv, 0);
    frame(16'hAAAA, 8'hF3);
    chk("pre-timeout dv", bus.dv, 1);
    chk("pre-timeout D", bus.D, 4'hD);
    repeat (TO) @(posedge clk);
    #1;
    chk("timeout edge vt", bus.vt, 1);
    @(posedge clk);
    #1;
    chk("timeout vt", bus.vt, 0);
    chk("timeout D held", bus.D, 4'hD);
    chk("timeout state", dut.state, 2'(HUNT));
    chk("dv pulse total", dv_seen, 4);
    strobe(2'b01);
    frame(16'hAAAA, 8'hCC);
    frame(16'hAAAA, 8'hCC);
    chk("pre-reset dv", bus.dv, 1);
    chk("pre-reset D", bus.D, 4'hA);
    #1;
    reset = 1'b1;
    #1;
    chk("async reset D", bus.D, 0);
    chk("async reset dv", bus.dv, 0);
    chk("async reset vt", bus.vt, 0);
    chk("async reset frame_err", bus.frame_err, 0);
    chk("async reset state", dut.state, 2'(HUNT));
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
